// File: rtl/sc_conv_scheduler_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sc_conv_scheduler_if
// Description : Bundle of request, stochastic-stream and result handshake
//               signals shared between the stochastic compute lanes and the
//               conversion scheduler.
//   req       : per-channel conversion request (level)
//   sc_bit    : per-channel serial stochastic bit
//   maxnum    : full-scale value, captured at grant
//   grant     : one-hot grant, high while a channel's window is sampled
//   busy      : scheduler not idle
//   res_valid : result valid
//   res_ready : consumer accepts result
//   res_data  : scaled binary result
//   res_ch    : channel index of res_data
//   modports  : master = lanes/consumer side, slave = scheduler side
// Revision    : 1.0 - initial release
// ============================================================================
interface sc_conv_scheduler_if #(
    parameter int N_CH = 4,
    parameter int MAXW = 9
);
    localparam int c_chw = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [N_CH-1:0]  req;
    logic [N_CH-1:0]  sc_bit;
    logic [MAXW-1:0]  maxnum;
    logic [N_CH-1:0]  grant;
    logic             busy;
    logic             res_valid;
    logic             res_ready;
    logic [MAXW-1:0]  res_data;
    logic [c_chw-1:0] res_ch;

    modport master (
        output req, sc_bit, maxnum, res_ready,
        input  grant, busy, res_valid, res_data, res_ch
    );

    modport slave (
        input  req, sc_bit, maxnum, res_ready,
        output grant, busy, res_valid, res_data, res_ch
    );
endinterface
`default_nettype wire

// File: rtl/sc_conv_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sc_conv_scheduler
// Description : Round-robin scheduler sharing one stochastic-to-binary
//               converter among N_CH bitstream sources. The granted channel's
//               ones are counted over 2**LEN serial bits, the count is scaled
//               by the captured full-scale value, and the result is offered
//               with its channel index on a valid/ready port.
// Ports       : clk   - rising-edge clock
//               rst_n - synchronous active-low reset
//               bus   - sc_conv_scheduler_if.slave (request, stream and
//                       result handshake signals)
// Revision    : 1.0 - initial release
// ============================================================================
module sc_conv_scheduler #(
    parameter int N_CH = 4,
    parameter int LEN  = 4,
    parameter int MAXW = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sc_conv_scheduler_if.slave    bus
);
    localparam int c_chw   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int c_prodw = LEN + 1 + MAXW;
    localparam logic [LEN-1:0]   c_cnt_last = '1;
    localparam logic [LEN-1:0]   c_cnt_one  = {{(LEN-1){1'b0}}, 1'b1};
    localparam logic [N_CH-1:0]  c_oh0      = {{(N_CH-1){1'b0}}, 1'b1};
    localparam logic [c_chw-1:0] c_ch_last  = c_chw'(N_CH - 1);
    localparam logic [c_chw-1:0] c_ch_one   = {{(c_chw-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_SCALE = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t              r_state, w_state;
    logic [N_CH-1:0]     r_grant, w_grant;
    logic                r_busy,  w_busy;
    logic                r_valid, w_valid;
    logic [MAXW-1:0]     r_data,  w_data;
    logic [c_chw-1:0]    r_ch,    w_ch;
    logic [c_chw-1:0]    r_ptr,   w_ptr;
    logic [c_chw-1:0]    r_win,   w_win;
    logic [MAXW-1:0]     r_max,   w_max;
    logic [LEN:0]        r_ones,  w_ones;
    logic [LEN-1:0]      r_cnt,   w_cnt;

    logic                w_found;
    logic [c_chw-1:0]    w_pick;
    int                  w_idx;
    logic [c_prodw-1:0]  w_prod;

    // Zero-extended operands keep the full product; ones <= 2**LEN guarantees
    // the shifted result never exceeds max_q, so truncating to MAXW is lossless.
    assign w_prod = {{MAXW{1'b0}}, r_ones} * {{(LEN+1){1'b0}}, r_max};

    always_comb begin
        w_state = r_state;
        w_grant = r_grant;
        w_valid = r_valid;
        w_data  = r_data;
        w_ch    = r_ch;
        w_ptr   = r_ptr;
        w_win   = r_win;
        w_max   = r_max;
        w_ones  = r_ones;
        w_cnt   = r_cnt;
        w_found = 1'b0;
        w_pick  = r_ptr;
        w_idx   = 0;

        // Round-robin search beginning at the pointer, wrapping at N_CH.
        for (int i = 0; i < N_CH; i++) begin
            w_idx = int'(r_ptr) + i;
            if (w_idx >= N_CH) begin
                w_idx = w_idx - N_CH;
            end
            if (!w_found && bus.req[c_chw'(w_idx)]) begin
                w_found = 1'b1;
                w_pick  = c_chw'(w_idx);
            end
        end

        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state = S_COUNT;
                    w_grant = c_oh0 << w_pick;
                    w_win   = w_pick;
                    w_max   = bus.maxnum;
                    w_ones  = '0;
                    w_cnt   = '0;
                end
            end
            S_COUNT: begin
                w_ones = r_ones + {{LEN{1'b0}}, bus.sc_bit[r_win]};
                w_cnt  = r_cnt + c_cnt_one;
                if (r_cnt == c_cnt_last) begin
                    // Drop grant on the last sampled bit so it is low in SCALE.
                    w_state = S_SCALE;
                    w_grant = '0;
                end
            end
            S_SCALE: begin
                w_data  = MAXW'(w_prod >> LEN);
                w_ch    = r_win;
                w_valid = 1'b1;
                w_grant = '0;
                w_ptr   = (r_win == c_ch_last) ? '0 : (r_win + c_ch_one);
                w_state = S_OUT;
            end
            S_OUT: begin
                if (r_valid && bus.res_ready) begin
                    w_valid = 1'b0;
                    w_state = S_IDLE;
                end
            end
            default: begin
                w_state = S_IDLE;
                w_grant = '0;
                w_valid = 1'b0;
            end
        endcase

        w_busy = (w_state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ch    <= '0;
            r_ptr   <= '0;
            r_win   <= '0;
            r_max   <= '0;
            r_ones  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state;
            r_grant <= w_grant;
            r_busy  <= w_busy;
            r_valid <= w_valid;
            r_data  <= w_data;
            r_ch    <= w_ch;
            r_ptr   <= w_ptr;
            r_win   <= w_win;
            r_max   <= w_max;
            r_ones  <= w_ones;
            r_cnt   <= w_cnt;
        end
    end

    assign bus.grant     = r_grant;
    assign bus.busy      = r_busy;
    assign bus.res_valid = r_valid;
    assign bus.res_data  = r_data;
    assign bus.res_ch    = r_ch;

endmodule
`default_nettype wire

// File: doc/sc_conv_scheduler.md
# sc_conv_scheduler

Round-robin scheduler that shares one stochastic-to-binary conversion datapath among `N_CH` stochastic bitstream sources. It arbitrates conversion requests and grants one channel at a time. For the granted channel it counts ones over a fixed window of `2**LEN` serial bits, then scales the count by a run-time full-scale value `maxnum`. The binary result and its channel index are delivered on a valid/ready output port. The block sits between the stochastic compute lanes and the binary-domain consumers.

## Interface

Parameters:

- `N_CH`, 4: number of requesting channels (≥2).
- `LEN`, 4: log2 of the conversion window; window = `2**LEN` bits.
- `MAXW`, 9: width of `maxnum` and `res_data`.

Ports:

- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: synchronous, active-low reset.
- `req`, input, `N_CH`: per-channel conversion request (level).
- `sc_bit`, input, `N_CH`: per-channel serial stochastic bit.
- `maxnum`, input, `MAXW`: full-scale value, sampled at grant.
- `grant`, output, `N_CH`: one-hot; the channel must present its stream bits while its grant is high.
- `busy`, output, 1: high in any state other than IDLE.
- `res_valid`, output, 1: result valid.
- `res_ready`, input, 1: consumer accepts the result.
- `res_data`, output, `MAXW`: converted binary value.
- `res_ch`, output, `$clog2(N_CH)`: channel index of `res_data`.

## Operation

- FSM states: IDLE, COUNT, SCALE, OUT.
- **IDLE**
  - If `req != 0`, select a winner by round-robin, starting the search at `ptr`.
  - Register the winner's one-hot value into `grant` and capture `maxnum` into `max_q`.
  - Clear `ones` (width `LEN+1`) and `cnt` (width `LEN`), then go to COUNT.
  - If `req == 0`, stay in IDLE.
- **COUNT**
  - Each cycle: `ones += sc_bit[winner]` and `cnt += 1`.
  - After sampling the bit when `cnt == 2**LEN-1`, go to SCALE.
  - Exactly `2**LEN` bits are sampled per conversion.
- **SCALE**
  - Compute `res_data <= (ones * max_q) >> LEN`, with the product width `LEN+1+MAXW`. The result is a floor.
  - If `ones == 2**LEN`, the result equals `max_q` exactly.
  - Set `res_ch <= winner` and `res_valid <= 1`, clear `grant`, set `ptr <= winner+1` (mod `N_CH`), and go to OUT.
- **OUT**
  - Hold `res_valid`, `res_data` and `res_ch` stable until `res_valid && res_ready` at a rising edge.
  - On that edge: `res_valid <= 0`, go to IDLE.
- `req` is sampled only in IDLE. Deasserting `req` during COUNT does not abort the window; the conversion completes.
- A held `maxnum` change after the grant cycle has no effect on the current conversion.
- No new grant is issued while a result is pending, so output backpressure stalls arbitration.
- `grant` is never multi-hot. It is all-zero outside COUNT.

## Timing

- Reset (`rst_n` low at a rising edge) forces the following, regardless of state:
  - state = IDLE;
  - `grant` = 0, `busy` = 0, `res_valid` = 0, `res_data` = 0, `res_ch` = 0;
  - `ptr` = 0, so channel 0 has highest priority;
  - `ones` = 0 and `cnt` = 0.
- Reset in mid-COUNT or mid-OUT discards the conversion. No partial result is ever emitted.
- Cycle `t`: IDLE sees `req`.
- Cycles `t+1` to `t+2**LEN`: `grant` is high and the bits are sampled.
- Cycle `t+2**LEN+1`: SCALE; `grant` is low.
- Cycle `t+2**LEN+2`: `res_valid` is high, at the earliest.
- Minimum spacing between grants is `2**LEN+3` cycles. This includes the mandatory IDLE cycle after the handshake.
- `busy` is registered. It is high from cycle `t+1` through the handshake cycle.

## Test plan

(Defaults used: `N_CH=4`, `LEN=4`.)

1. Only `req[2]=1`, `sc_bit[2]` all ones, `maxnum=300`, `res_ready=1` → `grant=4'b0100` for 16 cycles; `res_valid` at t+18 with `res_data=300`, `res_ch=2`.
2. `req[0]=1`, `sc_bit[0]` alternating 1,0,… (8 ones), `maxnum=511` → `res_data=255`. Repeat with all zeros → `res_data=0`.
3. `req=4'b1111` held, `res_ready=1` → successive grants in order ch0, ch1, ch2, ch3, ch0; `grant` is never multi-hot.
4. `res_ready=0` for 5 cycles after `res_valid` → `res_valid`, `res_data` and `res_ch` stay stable, `grant` stays 0, and no new window starts. After the handshake: one IDLE cycle, then the next grant.
5. `rst_n` low for 1 cycle at COUNT cycle 7 → `grant` = 0 and `res_valid` = 0 next cycle. A subsequent `req[3]` gives a full fresh 16-cycle window, and `ptr` restarts at 0.
6. `maxnum=100` at grant, changed to 400 during COUNT, 16 ones → `res_data=100`. `req` dropped mid-window → the window still completes and a result is delivered.
